floor_request_scheduler: RTL and testbench
==========================================

# floor_request_scheduler

Upstream stage of `elevator_control_top`. Latches car/hall button presses into a pending-floor bitmap and picks the next target with a SCAN (sweep) policy. Presents each target on `requested_floor` as a pulse, then clears the floor once the controller reports arrival with the door open. Encoding matches the controller: `requested_floor == 0` means no request, and floors are numbered `1..NUM_FLOORS-1`.

## Interface
Parameters:
- `NUM_FLOORS`, 16: floor count including the reserved index 0.
- `FLOOR_W`, 4: floor index width; requires `2**FLOOR_W >= NUM_FLOORS`.
- `ISSUE_CYCLES`, 1: number of cycles `requested_floor` is held non-zero per issue (≥1).
- `WAIT_TIMEOUT`, 64: cycles in WAIT before a reissue (used only with `REQ_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low; 0 at a rising edge resets the block.
- `btn_req`, in, `NUM_FLOORS`: level button presses, multi-hot; bit 0 ignored.
- `current_floor`, in, `FLOOR_W`: from the controller.
- `door_open`, in, 1: from the controller.
- `requested_floor`, out, `FLOOR_W`: target floor pulse to the controller; 0 means idle.
- `pending`, out, `NUM_FLOORS`: registered bitmap of outstanding requests.
- `sweep_up`, out, 1: current sweep direction; 1 means up.
- `busy`, out, 1: 1 whenever state ≠ IDLE.

## Operation
- Reset values: `pending=0`, `requested_floor=0`, `sweep_up=1`, `busy=0`, state IDLE, target register 0, timers 0.

Pending bitmap:
- Each cycle: `pending <= (pending | btn_req_masked) & ~clr`.
- `btn_req_masked` clears bit 0, and clears bit `current_floor` while `door_open=1`. A press at an open door is absorbed, never latched.
- `clr` is one-hot on `target` only in the SERVICE transition cycle. A press on `target` in that same cycle is absorbed; presses on other floors are latched.

Target selection (combinational, evaluated in IDLE):
- If `sweep_up=1`: take the lowest pending floor above `current_floor`. If none, flip `sweep_up` and take the highest pending floor below `current_floor`.
- If `sweep_up=0`: mirror image of the above.
- `pending[current_floor]` is never selected while `door_open=1`.
- With `door_open=0`, a pending bit at `current_floor` is selected (distance 0) ahead of any sweep search.

FSM:
- IDLE: if a selection exists, load `target`, go to ISSUE. Otherwise stay; `requested_floor=0`.
- ISSUE: `requested_floor=target` for exactly `ISSUE_CYCLES` cycles, then `requested_floor=0` and go to WAIT.
- WAIT: when `current_floor==target && door_open==1`, go to SERVICE.
- SERVICE (1 cycle): clear `pending[target]`, go to IDLE.
- Reset asserted in any state returns everything to reset values at that edge, including a half-issued pulse. Pending requests are lost.

## Timing
- Press sampled at edge N → `pending` bit visible after N.
- If in IDLE and that bit is the selection: state is ISSUE and `requested_floor=target` after N+1, held through N+`ISSUE_CYCLES`, and 0 after N+`ISSUE_CYCLES`+1.
- Arrival condition sampled at edge M while in WAIT → SERVICE after M → pending bit cleared and state IDLE after M+1. The next issue appears at the earliest after M+2.
- `sweep_up` flips in the same edge that loads `target`.
- The block never drives two non-zero targets back-to-back without an intervening 0 cycle.

## Configuration
- `FLOOR_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles. At count `WAIT_TIMEOUT` with no arrival, it returns to ISSUE and re-pulses the same `target`; the counter restarts.
  - `target` is not reselected.
- Undefined: WAIT waits indefinitely and no counter is instantiated.

## Test plan
- Reset: hold `reset=0` 2 cycles with `btn_req=16'hFFFF` → `pending=0`, `requested_floor=0`, `sweep_up=1`, `busy=0`.
- Single request: `current_floor=0`, pulse `btn_req[3]` → `requested_floor=3` for 1 cycle starting 2 edges after the press. Then drive `current_floor=3`, `door_open=1` → `pending[3]` clears 2 edges later; `busy=0`.
- SCAN order:
  - Setup: `current_floor=5`, `sweep_up=1`, pending {2,7,9}.
  - Required issue order: 7, 9, then `sweep_up` flips to 0 and 2 is issued.
- Absorbed press: `current_floor=4`, `door_open=1`, press 4 → `pending[4]` stays 0 and there is no issue.
- Same-cycle clear and press:
  - Setup: in SERVICE for target 6, press 6 and 8 in that cycle.
  - Required: `pending[6]=0`, `pending[8]=1`, next issue is 8.
- With `FLOOR_SCHED_TIMEOUT_EN` and `WAIT_TIMEOUT=64`: target 3 never arrives → `requested_floor=3` re-pulsed 64 cycles after entering WAIT, and again every 64+`ISSUE_CYCLES` cycles after that.

Source files
------------

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
// Latches button presses into a pending-floor bitmap and issues SCAN-ordered
// targets to the elevator controller as short pulses on requested_floor.
// Optional feature macro: FLOOR_SCHED_TIMEOUT_EN re-pulses a target whose
// arrival has not been reported within WAIT_TIMEOUT cycles.
module floor_request_scheduler #(
    parameter int NUM_FLOORS   = 16,
    parameter int FLOOR_W      = 4,
    parameter int ISSUE_CYCLES = 1,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SERVICE} state_t;

    localparam int ISSUE_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(ISSUE_CYCLES - 1);

    state_t                state, next_state;
    logic [FLOOR_W-1:0]    target, next_target;
    logic                  next_sweep_up;
    logic [ISSUE_W-1:0]    issue_cnt, next_issue_cnt;
    logic [NUM_FLOORS-1:0] cur_onehot, tgt_onehot, btn_masked, avail, clr;
    logic                  above_found, below_found, here_hit;
    logic [FLOOR_W-1:0]    above_floor, below_floor;
    logic                  sel_valid, sel_flip;
    logic [FLOOR_W-1:0]    sel_floor;
    logic                  arrived;

`ifdef FLOOR_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
    logic [WAIT_W-1:0] wait_cnt, next_wait_cnt;
`endif

    // Decode floor indices into bitmaps and mask presses that must be absorbed
    always_comb begin
        cur_onehot = '0;
        tgt_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_onehot[i] = (FLOOR_W'(i) == current_floor);
            tgt_onehot[i] = (FLOOR_W'(i) == target);
        end
        btn_masked    = btn_req & ~(door_open ? cur_onehot : '0);
        btn_masked[0] = 1'b0;
        avail         = pending & ~(door_open ? cur_onehot : '0);
        avail[0]      = 1'b0;
    end

    // SCAN selection: current floor first, then along the sweep, then reversed
    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 1; i--) begin
            if (avail[i] && (FLOOR_W'(i) > current_floor)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 1; i < NUM_FLOORS; i++) begin
            if (avail[i] && (FLOOR_W'(i) < current_floor)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
        here_hit  = |(avail & cur_onehot);
        sel_valid = 1'b0;
        sel_flip  = 1'b0;
        sel_floor = '0;
        if (here_hit) begin
            sel_valid = 1'b1;
            sel_floor = current_floor;
        end else if (sweep_up) begin
            if (above_found) begin
                sel_valid = 1'b1;
                sel_floor = above_floor;
            end else if (below_found) begin
                sel_valid = 1'b1;
                sel_flip  = 1'b1;
                sel_floor = below_floor;
            end
        end else begin
            if (below_found) begin
                sel_valid = 1'b1;
                sel_floor = below_floor;
            end else if (above_found) begin
                sel_valid = 1'b1;
                sel_flip  = 1'b1;
                sel_floor = above_floor;
            end
        end
    end

    // Next-state logic for the issue / wait / service handshake
    always_comb begin
        next_state     = state;
        next_target    = target;
        next_sweep_up  = sweep_up;
        next_issue_cnt = issue_cnt;
        clr            = '0;
        arrived        = (current_floor == target) && door_open;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    next_target    = sel_floor;
                    next_sweep_up  = sel_flip ? ~sweep_up : sweep_up;
                    next_issue_cnt = '0;
                    next_state     = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_cnt == ISSUE_LAST) begin
                    next_issue_cnt = '0;
                    next_state     = WAIT;
                end else begin
                    next_issue_cnt = issue_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (arrived) begin
                    next_state = SERVICE;
`ifdef FLOOR_SCHED_TIMEOUT_EN
                end else if (wait_cnt == WAIT_LAST) begin
                    next_issue_cnt = '0;
                    next_state     = ISSUE;
`endif
                end
            end
            SERVICE: begin
                clr        = tgt_onehot;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef FLOOR_SCHED_TIMEOUT_EN
    // WAIT dwell counter restarts whenever WAIT is entered or left
    always_comb begin
        next_wait_cnt = '0;
        if (state == WAIT && next_state == WAIT) begin
            next_wait_cnt = wait_cnt + 1'b1;
        end
    end

    // Register the WAIT dwell counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= next_wait_cnt;
        end
    end
`endif

    // State, target, sweep direction and pending bitmap registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            target    <= '0;
            sweep_up  <= 1'b1;
            issue_cnt <= '0;
            pending   <= '0;
        end else begin
            state     <= next_state;
            target    <= next_target;
            sweep_up  <= next_sweep_up;
            issue_cnt <= next_issue_cnt;
            pending   <= (pending | btn_masked) & ~clr;
        end
    end

    assign requested_floor = (state == ISSUE) ? target : '0;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Testbench for floor_request_scheduler: directed scenarios with a scoreboard
// queue of expected issue targets checked by a pulse monitor.
module tb_floor_request_scheduler;

    localparam int NUM_FLOORS   = 16;
    localparam int FLOOR_W      = 4;
    localparam int ISSUE_CYCLES = 1;
    localparam int WAIT_TIMEOUT = 64;

    logic                  clk;
    logic                  reset;
    logic [NUM_FLOORS-1:0] btn_req;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [FLOOR_W-1:0]    requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  sweep_up;
    logic                  busy;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int run_len   = 0;
    logic [FLOOR_W-1:0] prev_req = '0;
    logic [FLOOR_W-1:0] exp_q[$];

    floor_request_scheduler #(
        .NUM_FLOORS  (NUM_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .ISSUE_CYCLES(ISSUE_CYCLES),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_req        (btn_req),
        .current_floor  (current_floor),
        .door_open      (door_open),
        .requested_floor(requested_floor),
        .pending        (pending),
        .sweep_up       (sweep_up),
        .busy           (busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_FLOORS-1:0] btn, input logic [FLOOR_W-1:0] cf,
                                 input logic door);
        btn_req       = btn;
        current_floor = cf;
        door_open     = door;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIssue();
        int n = 0;
        while (requested_floor == '0 && n < 20) begin
            tick();
            n++;
        end
        if (requested_floor == '0) checkOutput("issue_timeout", 0, 1);
    endtask

    // Wait for the next issue, then report arrival at floor tgt with the door open
    task automatic arriveAt(input logic [FLOOR_W-1:0] tgt);
        waitIssue();
        applyStimulus('0, tgt, 1'b1);
        tick();
        tick();
        checkOutput("svc_busy", 32'(busy), 1);
        tick();
        checkOutput("svc_idle", 32'(busy), 0);
        checkOutput("svc_clear", 32'(pending[tgt]), 0);
        applyStimulus('0, tgt, 1'b0);
    endtask

    // Compare each new non-zero pulse against the scoreboard and check pulse width
    always @(negedge clk) begin
        if (requested_floor != '0 && prev_req == '0) begin
            if (exp_q.size() == 0) checkOutput("unexpected_issue", 32'(requested_floor), 0);
            else checkOutput("issue_order", 32'(requested_floor), 32'(exp_q.pop_front()));
        end
        if (requested_floor != '0) begin
            run_len++;
        end else begin
            if (run_len != 0) checkOutput("pulse_len", run_len, ISSUE_CYCLES);
            run_len = 0;
        end
        prev_req = requested_floor;
    end

    initial begin
        reset = 1'b0;
        applyStimulus(16'hFFFF, '0, 1'b0);
        tick();
        tick();
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_req", 32'(requested_floor), 0);
        checkOutput("rst_sweep", 32'(sweep_up), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        applyStimulus('0, 4'd0, 1'b0);
        reset = 1'b1;
        tick();

        // Single request with exact issue timing
        applyStimulus(16'h0008, 4'd0, 1'b0);
        exp_q.push_back(4'd3);
        tick();
        checkOutput("single_pend", 32'(pending), 32'h0008);
        applyStimulus('0, 4'd0, 1'b0);
        tick();
        checkOutput("single_req_on", 32'(requested_floor), 3);
        checkOutput("single_busy", 32'(busy), 1);
        tick();
        checkOutput("single_req_off", 32'(requested_floor), 0);
        applyStimulus('0, 4'd3, 1'b1);
        tick();
        checkOutput("single_svc_pend", 32'(pending[3]), 1);
        tick();
        checkOutput("single_cleared", 32'(pending), 0);
        checkOutput("single_idle", 32'(busy), 0);
        applyStimulus('0, 4'd3, 1'b0);
        tick();

        // SCAN order from floor 5 sweeping up with {2,7,9} pending
        applyStimulus('0, 4'd5, 1'b0);
        tick();
        checkOutput("scan_sweep0", 32'(sweep_up), 1);
        applyStimulus(16'h0284, 4'd5, 1'b0);
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd2);
        tick();
        applyStimulus('0, 4'd5, 1'b0);
        checkOutput("scan_pend", 32'(pending), 32'h0284);
        arriveAt(4'd7);
        arriveAt(4'd9);
        checkOutput("scan_sweep_pre", 32'(sweep_up), 1);
        tick();
        checkOutput("scan_req2", 32'(requested_floor), 2);
        checkOutput("scan_sweep_flip", 32'(sweep_up), 0);
        arriveAt(4'd2);

        // Press at an open door is absorbed and never issued
        applyStimulus('0, 4'd4, 1'b1);
        tick();
        applyStimulus(16'h0010, 4'd4, 1'b1);
        tick();
        checkOutput("absorb_pend", 32'(pending), 0);
        applyStimulus('0, 4'd4, 1'b1);
        tick();
        applyStimulus('0, 4'd4, 1'b0);
        tick();
        tick();
        checkOutput("absorb_idle", 32'(busy), 0);

        // Press on the target during SERVICE is absorbed; another floor latches
        applyStimulus(16'h0040, 4'd4, 1'b0);
        exp_q.push_back(4'd6);
        tick();
        applyStimulus('0, 4'd4, 1'b0);
        waitIssue();
        applyStimulus('0, 4'd6, 1'b1);
        tick();
        tick();
        checkOutput("same_svc_busy", 32'(busy), 1);
        applyStimulus(16'h0140, 4'd0, 1'b1);
        exp_q.push_back(4'd8);
        tick();
        checkOutput("same_pend", 32'(pending), 32'h0100);
        checkOutput("same_idle", 32'(busy), 0);
        applyStimulus('0, 4'd0, 1'b1);
        arriveAt(4'd8);

        // Reset in the middle of an issue pulse
        applyStimulus(16'h0020, 4'd8, 1'b0);
        exp_q.push_back(4'd5);
        tick();
        applyStimulus('0, 4'd8, 1'b0);
        waitIssue();
        checkOutput("mid_req", 32'(requested_floor), 5);
        checkOutput("mid_sweep", 32'(sweep_up), 0);
        reset = 1'b0;
        tick();
        checkOutput("mid_rst_req", 32'(requested_floor), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_sweep", 32'(sweep_up), 1);
        checkOutput("mid_rst_pend", 32'(pending), 0);
        reset = 1'b1;
        tick();

`ifdef FLOOR_SCHED_TIMEOUT_EN
        // Target never reached: re-pulse after WAIT_TIMEOUT cycles in WAIT
        applyStimulus(16'h0008, 4'd0, 1'b0);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd3);
        tick();
        applyStimulus('0, 4'd0, 1'b0);
        waitIssue();
        for (int i = 0; i < ISSUE_CYCLES + WAIT_TIMEOUT; i++) tick();
        checkOutput("timeout_repulse", 32'(requested_floor), 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        tick();
        checkOutput("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
